// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding, memory geometry defaults and index helper
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 16;

  // Circular successor of a requester index; handles non-power-of-two counts.
  function automatic int wrap_inc(input int i, input int n);
    return (i >= n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rtl/mem_port_arbiter_rr_pick.sv - combinational circular priority encoder starting at ptr
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;
  int             sum;

  // Rotate so that bit 0 of rot corresponds to requester ptr.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    off = 0;
    any = |rot;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    grant = W'(sum);
  end

endmodule

// File: rtl/simple_dp_mem.sv
// rtl/simple_dp_mem.sv - single-clock dual-port RAM, one write port and one registered read port
module simple_dp_mem #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] dat_in,
  input  logic [ADDR_W-1:0] rd_adr,
  output logic [DATA_W-1:0] dat_out
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_adr] <= dat_in;
    dat_out <= mem[rd_adr];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter with bounded lock, sharing one simple_dp_mem
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      lock_expired
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  arb_state_e        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  pick_g;
  logic [PTR_W-1:0]  g;
  logic              pick_any;
  logic              issue;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              cnt_hit;
  logic [ADDR_W-1:0] adr_q;
  logic [ADDR_W-1:0] mem_adr;
  logic              wr_en;

  rr_pick #(.N(NUM_REQ), .W(PTR_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_g),
    .any   (pick_any)
  );

  always_comb begin
    ack   = '0;
    issue = 1'b0;
    g     = pick_g;
    if (state == ARB) begin
      issue = pick_any;
    end else if (req[owner]) begin
      issue = 1'b1;
      g     = owner;
    end
    if (issue) ack[g] = 1'b1;
  end

  assign cnt_next = lock_cnt + 1'b1;
  assign cnt_hit  = (cnt_next == CNT_MAX);
  // Address holds its last issued value on idle cycles.
  assign mem_adr  = issue ? addr[g*ADDR_W +: ADDR_W] : adr_q;
  assign wr_en    = issue & we[g];

  simple_dp_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_adr  (mem_adr),
    .dat_in  (wdata[g*DATA_W +: DATA_W]),
    .rd_adr  (mem_adr),
    .dat_out (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ARB;
      ptr          <= '0;
      owner        <= '0;
      lock_cnt     <= '0;
      rd_valid     <= '0;
      lock_expired <= 1'b0;
      adr_q        <= '0;
    end else begin
      rd_valid     <= ack & ~we;
      lock_expired <= 1'b0;
      if (issue) adr_q <= mem_adr;
      case (state)
        ARB: begin
          if (issue) begin
            ptr <= PTR_W'(wrap_inc(int'(g), NUM_REQ));
            if (lock[g]) begin
              state    <= LOCKED;
              owner    <= g;
              lock_cnt <= CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          if (issue) lock_cnt <= cnt_next;
          if (!issue || !lock[owner] || cnt_hit) begin
            state <= ARB;
            ptr   <= PTR_W'(wrap_inc(int'(owner), NUM_REQ));
          end
          if (issue && cnt_hit) lock_expired <= 1'b1;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
